// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD lap stopwatch.
// Provides the FSM state enum, BCD digit type, blank code and 7-segment decoder.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    // All segments off, expressed in active-low polarity.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment order {g,f,e,d,c,b,a}; table is active-low, inverted otherwise.
    function automatic logic [6:0] seg_decode(
        input bcd_t digit,
        input logic active_low
    );
        logic [6:0] seg;
        unique case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return active_low ? seg : ~seg;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_lap_digit.sv
// Single BCD digit counter 0..MAX with ripple carry for the stopwatch chain.
// Ports: clock, reset (sync, active-low), i_clr, i_inc -> o_digit, o_carry.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output bcd_t o_digit,
    output logic o_carry
);

    localparam bcd_t MAXV = bcd_t'(MAX);

    bcd_t r_digit;

    always_ff @(posedge clock) begin
        if (!reset || i_clr) begin
            r_digit <= '0;
        end else if (i_inc) begin
            r_digit <= (r_digit == MAXV) ? '0 : r_digit + 4'd1;
        end
    end

    assign o_digit = r_digit;
    assign o_carry = i_inc && (r_digit == MAXV);

endmodule

// File: rtl/stopwatch_bcd_lap.sv
// MM:SS.hh stopwatch with start/stop, pause, lap freeze, clear and wrap pulse.
// Ports: clock, reset (sync, active-low), i_start_stop, i_lap, i_clear (levels);
//        o_hex0..o_hex5 segments {g,f,e,d,c,b,a}, o_running, o_lap_active, o_wrap.
// Build option: STOPWATCH_LEAD_ZERO_BLANK_EN blanks leading zeros on hex5..hex3.
// DIV = CLK_HZ/TICK_HZ must be an integer >= 2.
module stopwatch_bcd_lap
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned TICK_HZ        = 100,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    output logic [6:0] o_hex0,
    output logic [6:0] o_hex1,
    output logic [6:0] o_hex2,
    output logic [6:0] o_hex3,
    output logic [6:0] o_hex4,
    output logic [6:0] o_hex5,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_wrap
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    sw_state_t     r_state;
    sw_state_t     w_state_nxt;
    logic [PW-1:0] r_presc;
    logic          r_ss_q;
    logic          r_lap_q;
    logic          r_lap_active;
    bcd_t [5:0]    r_lap;
    logic          r_wrap;

    logic          w_ss_edge;
    logic          w_lap_edge;
    logic          w_tick;
    logic          w_c0, w_c1, w_c2, w_c3, w_c4, w_c5;
    logic [5:0]    w_inc;
    logic [5:0]    w_cy;
    bcd_t [5:0]    w_live;
    bcd_t [5:0]    w_nxt;
    bcd_t [5:0]    w_disp;
    logic          w_blank3, w_blank4, w_blank5;
    logic [6:0]    w_seg_off;

    // Edge detectors survive clear; only reset zeroes them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ss_q  <= 1'b0;
            r_lap_q <= 1'b0;
        end else begin
            r_ss_q  <= i_start_stop;
            r_lap_q <= i_lap;
        end
    end

    assign w_ss_edge  = i_start_stop && !r_ss_q;
    assign w_lap_edge = i_lap && !r_lap_q;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = IDLE;
        end else if (w_ss_edge) begin
            unique case (r_state)
                IDLE:    w_state_nxt = RUN;
                RUN:     w_state_nxt = PAUSE;
                PAUSE:   w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        o_running = (r_state == RUN);
    end

    // Prescaler holds in PAUSE so resume keeps the fraction; IDLE is
    // only entered through reset/clear, so it always restarts from 0.
    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    assign w_tick = (r_state == RUN) && (r_presc == PRE_MAX);

    bcd_digit_counter #(.MAX(9)) u_h0 (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (i_clear),
        .i_inc   (w_tick),
        .o_digit (w_live[0]),
        .o_carry (w_c0)
    );

    bcd_digit_counter #(.MAX(9)) u_h1 (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (i_clear),
        .i_inc   (w_c0),
        .o_digit (w_live[1]),
        .o_carry (w_c1)
    );

    bcd_digit_counter #(.MAX(9)) u_s0 (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (i_clear),
        .i_inc   (w_c1),
        .o_digit (w_live[2]),
        .o_carry (w_c2)
    );

    bcd_digit_counter #(.MAX(5)) u_s1 (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (i_clear),
        .i_inc   (w_c2),
        .o_digit (w_live[3]),
        .o_carry (w_c3)
    );

    bcd_digit_counter #(.MAX(9)) u_m0 (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (i_clear),
        .i_inc   (w_c3),
        .o_digit (w_live[4]),
        .o_carry (w_c4)
    );

    bcd_digit_counter #(.MAX(5)) u_m1 (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (i_clear),
        .i_inc   (w_c4),
        .o_digit (w_live[5]),
        .o_carry (w_c5)
    );

    assign w_inc = {w_c4, w_c3, w_c2, w_c1, w_c0, w_tick};
    assign w_cy  = {w_c5, w_c4, w_c3, w_c2, w_c1, w_c0};

    // Value the digit chain will hold after this edge; the lap latch
    // captures this so the frozen time matches the count it froze on.
    always_comb begin
        w_nxt = w_live;
        for (int i = 0; i < 6; i++) begin
            if (w_inc[i]) begin
                w_nxt[i] = w_cy[i] ? 4'd0 : w_live[i] + 4'd1;
            end
        end
    end

    // Lap edge acts on the pre-transition state.
    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_lap_active <= 1'b0;
            r_lap        <= '0;
        end else if (w_lap_edge) begin
            if (r_lap_active) begin
                r_lap_active <= 1'b0;
            end else if (r_state == RUN) begin
                r_lap_active <= 1'b1;
                r_lap        <= w_nxt;
            end
        end
    end

    // Carry out of the top digit means 59:59.99 just rolled over.
    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_c5;
        end
    end

    assign o_wrap       = r_wrap;
    assign o_lap_active = r_lap_active;

    assign w_disp    = r_lap_active ? r_lap : w_live;
    assign w_seg_off = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

`ifdef STOPWATCH_LEAD_ZERO_BLANK_EN
    assign w_blank5 = (w_disp[5] == 4'd0);
    assign w_blank4 = w_blank5 && (w_disp[4] == 4'd0);
    assign w_blank3 = w_blank4 && (w_disp[3] == 4'd0);
`else
    assign w_blank5 = 1'b0;
    assign w_blank4 = 1'b0;
    assign w_blank3 = 1'b0;
`endif

    always_comb begin
        o_hex0 = seg_decode(w_disp[0], SEG_ACTIVE_LOW);
        o_hex1 = seg_decode(w_disp[1], SEG_ACTIVE_LOW);
        o_hex2 = seg_decode(w_disp[2], SEG_ACTIVE_LOW);
        o_hex3 = w_blank3 ? w_seg_off : seg_decode(w_disp[3], SEG_ACTIVE_LOW);
        o_hex4 = w_blank4 ? w_seg_off : seg_decode(w_disp[4], SEG_ACTIVE_LOW);
        o_hex5 = w_blank5 ? w_seg_off : seg_decode(w_disp[5], SEG_ACTIVE_LOW);
    end

endmodule

// File: tb/tb_stopwatch_bcd_lap.sv
// Scoreboard bench for stopwatch_bcd_lap: reference model counts centiseconds
// as an integer; every cycle's expected display/flags are queued and checked.
module tb_stopwatch_bcd_lap;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int FULL    = 360000;

    localparam logic [6:0] SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ss    = 1'b0;
    logic       lp    = 1'b0;
    logic       clr   = 1'b0;
    logic [6:0] h0, h1, h2, h3, h4, h5;
    logic       running, lap_active, wrap;

    always #5 clock = ~clock;

    stopwatch_bcd_lap #(
        .CLK_HZ         (CLK_HZ),
        .TICK_HZ        (TICK_HZ),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_start_stop (ss),
        .i_lap        (lp),
        .i_clear      (clr),
        .o_hex0       (h0),
        .o_hex1       (h1),
        .o_hex2       (h2),
        .o_hex3       (h3),
        .o_hex4       (h4),
        .o_hex5       (h5),
        .o_running    (running),
        .o_lap_active (lap_active),
        .o_wrap       (wrap)
    );

    typedef struct packed {
        logic [41:0] disp;
        logic [2:0]  flags;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   do_force = 1'b0;

    // Model: 0=idle 1=run 2=pause; time kept as centiseconds.
    int m_st, m_pre, m_cnt, m_lapcnt;
    bit m_lapact, m_wrap, m_pss, m_plap;

    function automatic logic [6:0] seg_of(input int d, input bit blank);
        return blank ? 7'b1111111 : SEG[d];
    endfunction

    function automatic logic [41:0] disp_of(input int c);
        int d[6];
        bit b5, b4, b3;
        d[0] = c % 10;
        d[1] = (c / 10) % 10;
        d[2] = (c / 100) % 10;
        d[3] = (c / 1000) % 6;
        d[4] = (c / 6000) % 10;
        d[5] = c / 60000;
        b5 = 1'b0;
        b4 = 1'b0;
        b3 = 1'b0;
`ifdef STOPWATCH_LEAD_ZERO_BLANK_EN
        b5 = (d[5] == 0);
        b4 = b5 && (d[4] == 0);
        b3 = b4 && (d[3] == 0);
`endif
        return {seg_of(d[5], b5), seg_of(d[4], b4), seg_of(d[3], b3),
                seg_of(d[2], 1'b0), seg_of(d[1], 1'b0), seg_of(d[0], 1'b0)};
    endfunction

    task automatic model_zero();
        m_st = 0; m_pre = 0; m_cnt = 0;
        m_lapact = 1'b0; m_lapcnt = 0; m_wrap = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit l, input bit c, input bit r);
        bit es, el, tick;
        int ncnt;
        if (!r) begin
            model_zero();
            m_pss = 1'b0;
            m_plap = 1'b0;
            return;
        end
        es = s && !m_pss;
        el = l && !m_plap;
        m_pss = s;
        m_plap = l;
        if (c) begin
            model_zero();
            return;
        end
        tick = (m_st == 1) && (m_pre == DIV - 1);
        ncnt = tick ? (m_cnt + 1) % FULL : m_cnt;
        m_wrap = tick && (m_cnt == FULL - 1);
        if (m_st == 1) m_pre = tick ? 0 : m_pre + 1;
        if (el) begin
            if (m_lapact) begin
                m_lapact = 1'b0;
            end else if (m_st == 1) begin
                m_lapact = 1'b1;
                m_lapcnt = ncnt;
            end
        end
        if (es) m_st = (m_st == 1) ? 2 : 1;
        m_cnt = ncnt;
    endtask

    task automatic step(input bit s, input bit l, input bit c, input bit r);
        exp_t e;
        @(negedge clock);
        if (do_force) begin
            force dut.u_m1.r_digit = 4'd5;
            force dut.u_m0.r_digit = 4'd9;
            force dut.u_s1.r_digit = 4'd5;
            force dut.u_s0.r_digit = 4'd9;
            force dut.u_h1.r_digit = 4'd9;
            force dut.u_h0.r_digit = 4'd9;
            #1;
            release dut.u_m1.r_digit;
            release dut.u_m0.r_digit;
            release dut.u_s1.r_digit;
            release dut.u_s0.r_digit;
            release dut.u_h1.r_digit;
            release dut.u_h0.r_digit;
            m_cnt = FULL - 1;
            do_force = 1'b0;
        end
        ss = s;
        lp = l;
        clr = c;
        reset = r;
        model_step(s, l, c, r);
        e.disp = disp_of(m_lapact ? m_lapcnt : m_cnt);
        e.flags = {m_st == 1, m_lapact, m_wrap};
        q.push_back(e);
    endtask

    // Monitor: one expected bundle per clock once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if ({h5, h4, h3, h2, h1, h0} !== e.disp) begin
                    n_fail++;
                    $display("FAIL display t=%0t act=%h exp=%h",
                             $time, {h5, h4, h3, h2, h1, h0}, e.disp);
                end
                n_checks++;
                if ({running, lap_active, wrap} !== e.flags) begin
                    n_fail++;
                    $display("FAIL flags(run,lap,wrap) t=%0t act=%b exp=%b",
                             $time, {running, lap_active, wrap}, e.flags);
                end
            end
        end
    end

    initial begin
        bit rs, rl;
        m_pss = 1'b0;
        m_plap = 1'b0;
        model_zero();

        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1);

        // Run from idle for 1000 cycles
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (1000) step(0, 0, 0, 1);

        // Pause with 00:00.03 shown and prescaler left at 4, then resume
        step(0, 0, 1, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 200 && !(m_pre == 3 && m_cnt == 3); i++)
            step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (50) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (20) step(0, 0, 0, 1);

        // Lap freeze at 00:02.50, release after the live count passes 3.00
        for (int i = 0; i < 5000 && m_cnt != 250; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 1000 && m_cnt < 300; i++) step(0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 1);

        // Wrap: load 59:59.99 while paused, resume and roll over
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        do_force = 1'b1;
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (30) step(0, 0, 0, 1);

        // Clear together with start_stop while running
        step(1, 0, 1, 1);
        step(0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 1);

        // Lap edge in IDLE ignored; simultaneous start_stop + lap in RUN
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (50) step(0, 0, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (200) step(0, 0, 0, 1);

        // Reset mid-count
        step(0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 1);

        // Random phase
        rs = 1'b0;
        rl = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 39) == 0) rs = !rs;
            if ($urandom_range(0, 24) == 0) rl = !rl;
            step(rs, rl, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 999) != 0);
        end

        step(0, 0, 0, 1);
        @(posedge clock);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain act=%0d exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_lap.md
Name: stopwatch_bcd_lap

Overview:
- Parametrised MM:SS.hh stopwatch driving six 7-segment displays; successor to the fixed three-counter clock display.
- One internal prescaler generates the hundredths tick. Cascaded BCD digit counters replace binary counters and binary-to-BCD conversion.
- Adds start/stop, pause/resume with the prescaler fraction retained, a lap (display freeze) function, clear, and a wrap pulse.
- Sits between debounced board keys and HEX0..HEX5.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 100, hundredths tick rate. CLK_HZ must be divisible by TICK_HZ. DIV = CLK_HZ/TICK_HZ must be >= 2.
- SEG_ACTIVE_LOW, 1, 1: segment on = 0; 0: segment on = 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- start_stop  in  1  level from debouncer; rising edge toggles run/pause.
- lap  in  1  level; rising edge toggles lap freeze.
- clear  in  1  level; high forces zero/IDLE.
- hex0..hex5  out  7 each  segments {g,f,e,d,c,b,a}. hex1:hex0 = hundredths, hex3:hex2 = seconds, hex5:hex4 = minutes.
- running  out  1  1 when state is RUN.
- lap_active  out  1  1 while the display is frozen.
- wrap  out  1  one-cycle pulse on 59:59.99 -> 00:00.00.

Behaviour:
- Edge detect: the previous values of start_stop and lap are registered. An edge is current=1 and previous=0. Both previous registers reset to 0.
- States: IDLE, RUN, PAUSE.
  - IDLE: a start_stop edge goes to RUN.
  - RUN: a start_stop edge goes to PAUSE.
  - PAUSE: a start_stop edge goes to RUN.
  - Any state: clear=1 goes to IDLE.
- Reset (reset=0 at a clock edge):
  - state=IDLE; prescaler=0; all digits 0; lap latch and lap_active=0; wrap=0.
  - Displays show 00:00.00 on the following cycle.
  - Reset mid-count behaves identically.
- Clear: same effect as reset except the edge-detect registers are kept. Clear has priority over start_stop and lap in the same cycle.
- Prescaler:
  - Counts 0..DIV-1, width $clog2(DIV), and only increments in RUN.
  - tick = (RUN and prescaler==DIV-1). Prescaler wraps to 0 on tick.
  - PAUSE holds the prescaler value, so resume continues the fraction.
  - Entering RUN from IDLE starts from prescaler 0.
  - The first tick occurs DIV clock cycles after the edge that entered RUN.
- Digits on tick:
  - h0 increments 0..9. On a carry it returns to 0 and h1 increments 0..9.
  - h1 carries into s0 0..9, s0 into s1 0..5, s1 into m0 0..9, m0 into m1 0..5.
  - Digit registers update on the tick cycle and are visible the next cycle.
- Wrap: at 59:59.99, a tick sets all digits to 0 and asserts wrap for exactly that one cycle. Counting continues; the state stays RUN.
- Lap:
  - A lap edge in RUN with lap_active=0 copies the next-state digit values into the lap latch and sets lap_active=1.
  - A lap edge with lap_active=1, in any state, clears lap_active.
  - A lap edge in IDLE or PAUSE with lap_active=0 is ignored.
  - Counting continues while lap_active=1.
- Simultaneous start_stop and lap edges in one cycle: both act. The lap uses the pre-transition state.
- Display source: lap latch when lap_active=1, else the live digits. Decode is combinational from registered digits.
- Segment codes, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Inverted when SEG_ACTIVE_LOW=0.

Optional Feature:
- Macro: STOPWATCH_LEAD_ZERO_BLANK_EN.
- Defined:
  - hex5 is blank (all segments off) when the displayed m1=0.
  - hex4 is blank when m1=0 and m0=0.
  - hex3 is blank when m1, m0 and s1 are all 0.
  - hex2..hex0 are never blanked.
- Undefined: every digit is always shown, including leading zeros.

Decomposition:
- Package stopwatch_pkg contains:
  - state enum {IDLE, RUN, PAUSE};
  - the 4-bit BCD digit typedef;
  - SEG_BLANK constant;
  - function seg_decode(digit, active_low) returning 7 bits.
- Sub-module bcd_digit_counter:
  - parameter MAX (9 or 5);
  - inputs: clock, reset, clr, inc;
  - outputs: digit, carry, where carry = inc and digit==MAX.
- Instantiated six times in a chain.

Test Plan:
- Run: CLK_HZ=1000, TICK_HZ=100 (DIV=10). Reset, then a start_stop edge -> hex0 shows 1 after 10 cycles; after 1000 cycles the display reads 00:01.00 and running=1.
- Pause/resume: pause at prescaler=4 with 00:00.03 shown, hold 50 cycles -> no change; resume -> 00:00.04 appears 6 cycles later.
- Wrap: force digits to 59:59.99 in RUN -> next tick gives 00:00.00 with wrap high for exactly 1 cycle; running stays 1.
- Lap: lap edge at 00:02.50 -> display frozen at 00:02.50 while the internal count reaches 00:03.00; second lap edge -> display shows the live 00:03.xx and lap_active=0.
- Simultaneous clear + start_stop in RUN -> IDLE, 00:00.00, running=0; reset=0 mid-count -> same.
- Blanking with STOPWATCH_LEAD_ZERO_BLANK_EN defined at 00:05.12 -> hex5, hex4, hex3 all off; hex2=5, hex1=1, hex0=2. Undefined -> hex5=0, hex4=0, hex3=0.
